// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the convolution sequencer and the datapath.
//   - scan_state_e : sequencer FSM states
//   - *_DEF        : default feature-map / kernel geometry
//   - out_dim()    : output extent for stride 1, no padding
//   - widx_w()     : width of the weight index (at least 1 bit)
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int K_DEF     = 3;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // A 1x1 kernel has a single weight, but a zero-width index port is illegal.
    function automatic int widx_w(input int k);
        return (k * k > 1) ? $clog2(k * k) : 1;
    endfunction

endpackage

// File: rtl/conv_idx_counter.sv
// conv_idx_counter: modulo-N counter used as one digit of the scan index.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force value to 0 (wins over en)
//   en       : advance by one
//   value    : current count, 0..N-1
//   wrap     : en && value==N-1; feeds the next digit's en
module conv_idx_counter #(
    parameter int N = 3,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] value_q, value_d;

    assign wrap  = en && (value_q == W'(N - 1));
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (clr || wrap) begin
            value_d = '0;
        end else if (en) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: walks every output position of an IMG_H x IMG_W map and every
// tap of a K x K kernel, emitting one pixel address + weight index per beat.
//   start / abort        : begin a scan (IDLE only) / cancel it (RUN only)
//   tap_valid, tap_ready : beat handshake; nothing moves while tap_ready=0
//   busy, done           : RUN indicator, one-cycle completion pulse
//   pix_addr, w_idx      : (out_row+kr)*IMG_W + out_col+kc, kr*K + kc
//   acc_first, acc_last  : first / last tap of the current window
//   out_row, out_col     : current output position
module conv_scan_ctrl
    import cnn_pkg::*;
#(
    parameter  int IMG_W  = IMG_W_DEF,
    parameter  int IMG_H  = IMG_H_DEF,
    parameter  int K      = K_DEF,
    parameter  int ADDR_W = 10,
    localparam int WIDX_W = widx_w(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              tap_ready,
    output logic              busy,
    output logic              done,
    output logic              tap_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [WIDX_W-1:0] w_idx,
    output logic              acc_first,
    output logic              acc_last,
    output logic [6:0]        out_row,
    output logic [6:0]        out_col
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;  // address of tap (0,0) of the window
    logic [ADDR_W-1:0] row_base_q, row_base_d;  // address of tap (kr,0)
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [WIDX_W-1:0] w_idx_q, w_idx_d;
    logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic first_q, first_d, last_q, last_d;

    logic       hs, clr_cnt, run_d;
    logic       kc_wrap, kr_wrap, col_wrap, row_wrap;
    logic [6:0] kc_val, kr_val, kc_n, kr_n;

    // abort outranks a handshake in the same cycle
    assign hs = (state_q == RUN) && tap_ready && !abort;

    conv_idx_counter #(.N(K), .W(7)) u_kc (
        .clk(clk), .rst(rst), .clr(clr_cnt), .en(hs),
        .value(kc_val), .wrap(kc_wrap));
    conv_idx_counter #(.N(K), .W(7)) u_kr (
        .clk(clk), .rst(rst), .clr(clr_cnt), .en(kc_wrap),
        .value(kr_val), .wrap(kr_wrap));
    conv_idx_counter #(.N(OUT_W), .W(7)) u_col (
        .clk(clk), .rst(rst), .clr(clr_cnt), .en(kr_wrap),
        .value(out_col), .wrap(col_wrap));
    conv_idx_counter #(.N(OUT_H), .W(7)) u_row (
        .clk(clk), .rst(rst), .clr(clr_cnt), .en(col_wrap),
        .value(out_row), .wrap(row_wrap));

    always_comb begin
        state_d    = state_q;
        win_base_d = win_base_q;
        row_base_d = row_base_q;
        pix_addr_d = pix_addr_q;
        clr_cnt    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) state_d = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    clr_cnt    = 1'b1;
                    win_base_d = '0;
                    row_base_d = '0;
                    pix_addr_d = '0;
                end else if (hs) begin
                    if (row_wrap) begin
                        state_d    = DONE;
                        win_base_d = '0;
                        row_base_d = '0;
                        pix_addr_d = '0;
                    end else if (col_wrap) begin
                        // col OUT_W-1 -> 0 and row+1: net move is IMG_W-(OUT_W-1) = K
                        win_base_d = win_base_q + ADDR_W'(K);
                        row_base_d = win_base_d;
                        pix_addr_d = win_base_d;
                    end else if (kr_wrap) begin
                        win_base_d = win_base_q + ADDR_W'(1);
                        row_base_d = win_base_d;
                        pix_addr_d = win_base_d;
                    end else if (kc_wrap) begin
                        row_base_d = row_base_q + ADDR_W'(IMG_W);
                        pix_addr_d = row_base_d;
                    end else begin
                        pix_addr_d = pix_addr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Tap position after this edge, so the strobes and w_idx register
        // alongside the counters.
        kc_n = (clr_cnt || kc_wrap) ? 7'd0 : kc_val + 7'(hs);
        kr_n = (clr_cnt || kr_wrap) ? 7'd0 : kr_val + 7'(kc_wrap);

        run_d   = (state_d == RUN);
        busy_d  = run_d;
        valid_d = run_d;
        done_d  = (state_d == DONE);
        w_idx_d = WIDX_W'(int'(kr_n) * K + int'(kc_n));
        first_d = run_d && (kc_n == 7'd0) && (kr_n == 7'd0);
        last_d  = run_d && (kc_n == 7'(K - 1)) && (kr_n == 7'(K - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_base_q <= '0;
            row_base_q <= '0;
            pix_addr_q <= '0;
            w_idx_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_base_q <= win_base_d;
            row_base_q <= row_base_d;
            pix_addr_q <= pix_addr_d;
            w_idx_q    <= w_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign tap_valid = valid_q;
    assign pix_addr  = pix_addr_q;
    assign w_idx     = w_idx_q;
    assign acc_first = first_q;
    assign acc_last  = last_q;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: three instances (5x5/K3, 4x4/K1, 3x3/K3) sharing
// clk, rst, abort and tap_ready, each with its own start.
module tb_conv_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic tap_ready = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    always #5 clk = ~clk;

    logic       busy_a, done_a, tap_valid_a, acc_first_a, acc_last_a;
    logic [9:0] pix_addr_a;
    logic [3:0] w_idx_a;
    logic [6:0] out_row_a, out_col_a;

    logic       busy_b, done_b, tap_valid_b, acc_first_b, acc_last_b;
    logic [9:0] pix_addr_b;
    logic [0:0] w_idx_b;
    logic [6:0] out_row_b, out_col_b;

    logic       busy_c, done_c, tap_valid_c, acc_first_c, acc_last_c;
    logic [9:0] pix_addr_c;
    logic [3:0] w_idx_c;
    logic [6:0] out_row_c, out_col_c;

    conv_scan_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .tap_ready(tap_ready),
        .busy(busy_a), .done(done_a), .tap_valid(tap_valid_a), .pix_addr(pix_addr_a),
        .w_idx(w_idx_a), .acc_first(acc_first_a), .acc_last(acc_last_a),
        .out_row(out_row_a), .out_col(out_col_a));

    conv_scan_ctrl #(.IMG_W(4), .IMG_H(4), .K(1), .ADDR_W(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .tap_ready(tap_ready),
        .busy(busy_b), .done(done_b), .tap_valid(tap_valid_b), .pix_addr(pix_addr_b),
        .w_idx(w_idx_b), .acc_first(acc_first_b), .acc_last(acc_last_b),
        .out_row(out_row_b), .out_col(out_col_b));

    conv_scan_ctrl #(.IMG_W(3), .IMG_H(3), .K(3), .ADDR_W(10)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort), .tap_ready(tap_ready),
        .busy(busy_c), .done(done_c), .tap_valid(tap_valid_c), .pix_addr(pix_addr_c),
        .w_idx(w_idx_c), .acc_first(acc_first_c), .acc_last(acc_last_c),
        .out_row(out_row_c), .out_col(out_col_c));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    // Checks every beat of a 5x5/K3 scan against the loop-nest formula.
    // toggle: tap_ready 1,0,1,0...; poke: raise start mid-scan and in DONE;
    // stop_beat >= 0: return while that beat is presented (no advance).
    task automatic scan_a(input bit toggle, input bit poke, input int stop_beat,
                          output int beats, output int cycles);
        int b, cyc, kc, kr, col, row;
        logic [9:0] ep;
        logic [3:0] ew;
        logic ef, el;
        bit stopped;
        b = 0; cyc = 0; stopped = 0;
        while (busy_a && cyc < 400) begin
            kc = b % 3; kr = (b / 3) % 3; col = (b / 9) % 3; row = b / 27;
            ep = 10'((row + kr) * 5 + col + kc);
            ew = 4'(kr * 3 + kc);
            ef = (b % 9 == 0);
            el = (b % 9 == 8);
            n_tests++;
            if ({tap_valid_a, pix_addr_a, w_idx_a, acc_first_a, acc_last_a, out_row_a, out_col_a}
                !== {1'b1, ep, ew, ef, el, 7'(row), 7'(col)}) begin
                n_fail++;
                $display("FAIL beat%0d: got valid=%b pix=%0d w=%0d first=%b last=%b row=%0d col=%0d; want valid=1 pix=%0d w=%0d first=%b last=%b row=%0d col=%0d",
                         b, tap_valid_a, pix_addr_a, w_idx_a, acc_first_a, acc_last_a,
                         out_row_a, out_col_a, ep, ew, ef, el, row, col);
            end
            if (b == stop_beat) begin
                stopped = 1;
                break;
            end
            tap_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            start_a   = poke && (cyc == 10 || cyc == 30);
            if (tap_ready) b++;
            step();
            cyc++;
        end
        start_a   = 1'b0;
        tap_ready = 1'b1;
        beats  = b;
        cycles = cyc;
        if (!stopped) begin
            n_tests++;
            if (busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_timeout: busy=%b after %0d cycles, want 0", busy_a, cyc);
            end
            n_tests++;
            if ({done_a, tap_valid_a, pix_addr_a} !== {1'b1, 1'b0, 10'd0}) begin
                n_fail++;
                $display("FAIL done_pulse: done=%b valid=%b pix=%0d, want done=1 valid=0 pix=0",
                         done_a, tap_valid_a, pix_addr_a);
            end
            start_a = poke;   // start during DONE must be ignored
            step();
            start_a = 1'b0;
            n_tests++;
            if ({done_a, busy_a} !== 2'b00) begin
                n_fail++;
                $display("FAIL done_one_cycle: done=%b busy=%b, want 0 0", done_a, busy_a);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if ({busy_a, done_a, tap_valid_a, acc_first_a, acc_last_a, pix_addr_a, w_idx_a,
             out_row_a, out_col_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: busy=%b done=%b valid=%b first=%b last=%b pix=%0d w=%0d row=%0d col=%0d, want all 0",
                     busy_a, done_a, tap_valid_a, acc_first_a, acc_last_a, pix_addr_a,
                     w_idx_a, out_row_a, out_col_a);
        end
        n_tests++;
        if ({busy_b, tap_valid_b, acc_first_b, busy_c, tap_valid_c, pix_addr_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_bc: busy_b=%b valid_b=%b first_b=%b busy_c=%b valid_c=%b pix_c=%0d, want all 0",
                     busy_b, tap_valid_b, acc_first_b, busy_c, tap_valid_c, pix_addr_c);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_scan(input bit toggle, input bit poke, input int want_cycles);
        int beats, cycles;
        start_scan_a();
        scan_a(toggle, poke, -1, beats, cycles);
        n_tests++;
        if (beats != 81) begin
            n_fail++;
            $display("FAIL beat_count: got %0d, want 81", beats);
        end
        n_tests++;
        if (cycles != want_cycles) begin
            n_fail++;
            $display("FAIL run_cycles: got %0d, want %0d", cycles, want_cycles);
        end
    endtask

    task automatic test_abort();
        int beats, cycles;
        start_scan_a();
        scan_a(1'b0, 1'b0, 19, beats, cycles);
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++;
        if ({busy_a, tap_valid_a, done_a, pix_addr_a, w_idx_a, acc_first_a, out_row_a, out_col_a} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b valid=%b done=%b pix=%0d w=%0d first=%b row=%0d col=%0d, want all 0",
                     busy_a, tap_valid_a, done_a, pix_addr_a, w_idx_a, acc_first_a, out_row_a, out_col_a);
        end
        step();
        n_tests++;
        if ({done_a, busy_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b busy=%b, want 0 0", done_a, busy_a);
        end
        test_full_scan(1'b0, 1'b0, 81);
    endtask

    task automatic test_start_abort_idle();
        start_a = 1'b1;
        abort   = 1'b1;
        step();
        start_a = 1'b0;
        abort   = 1'b0;
        n_tests++;
        if ({busy_a, tap_valid_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b valid=%b, want 0 0", busy_a, tap_valid_a);
        end
        step();
    endtask

    task automatic test_rst_mid_scan();
        int beats, cycles;
        start_scan_a();
        scan_a(1'b0, 1'b0, 39, beats, cycles);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({busy_a, done_a, tap_valid_a, acc_first_a, acc_last_a, pix_addr_a, w_idx_a,
             out_row_a, out_col_a} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_scan: busy=%b done=%b valid=%b first=%b last=%b pix=%0d w=%0d row=%0d col=%0d, want all 0",
                     busy_a, done_a, tap_valid_a, acc_first_a, acc_last_a, pix_addr_a,
                     w_idx_a, out_row_a, out_col_a);
        end
        step();
        n_tests++;
        if ({done_a, busy_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_no_done: done=%b busy=%b, want 0 0", done_a, busy_a);
        end
        test_full_scan(1'b0, 1'b0, 81);
    endtask

    // 4x4 with a 1x1 kernel: every beat is both first and last tap.
    task automatic test_k1();
        int b;
        b = 0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        while (busy_b && b < 40) begin
            n_tests++;
            if ({tap_valid_b, pix_addr_b, w_idx_b, acc_first_b, acc_last_b, out_row_b, out_col_b}
                !== {1'b1, 10'(b), 1'b0, 1'b1, 1'b1, 7'(b / 4), 7'(b % 4)}) begin
                n_fail++;
                $display("FAIL k1_beat%0d: valid=%b pix=%0d w=%0d first=%b last=%b row=%0d col=%0d; want pix=%0d w=0 first=1 last=1 row=%0d col=%0d",
                         b, tap_valid_b, pix_addr_b, w_idx_b, acc_first_b, acc_last_b,
                         out_row_b, out_col_b, b, b / 4, b % 4);
            end
            b++;
            step();
        end
        n_tests++;
        if (b != 16 || done_b !== 1'b1) begin
            n_fail++;
            $display("FAIL k1_count: beats=%0d done=%b, want 16 and 1", b, done_b);
        end
        step();
    endtask

    // 3x3 with a 3x3 kernel: a single window of 9 taps.
    task automatic test_single_window();
        int b;
        b = 0;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        while (busy_c && b < 40) begin
            n_tests++;
            if ({tap_valid_c, pix_addr_c, w_idx_c, acc_first_c, acc_last_c, out_row_c, out_col_c}
                !== {1'b1, 10'(b), 4'(b), (b == 0), (b == 8), 7'd0, 7'd0}) begin
                n_fail++;
                $display("FAIL win_beat%0d: valid=%b pix=%0d w=%0d first=%b last=%b row=%0d col=%0d; want pix=%0d w=%0d row=0 col=0",
                         b, tap_valid_c, pix_addr_c, w_idx_c, acc_first_c, acc_last_c,
                         out_row_c, out_col_c, b, b);
            end
            b++;
            step();
        end
        n_tests++;
        if (b != 9 || done_c !== 1'b1) begin
            n_fail++;
            $display("FAIL win_count: beats=%0d done=%b, want 9 and 1", b, done_c);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_full_scan(1'b0, 1'b0, 81);    // back-to-back taps
        test_full_scan(1'b1, 1'b0, 161);   // tap_ready 1,0,1,0
        test_full_scan(1'b0, 1'b1, 81);    // start poked mid-scan and in DONE
        test_start_abort_idle();
        test_abort();
        test_rst_mid_scan();
        test_k1();
        test_single_window();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_scan_ctrl.md
# conv_scan_ctrl

Sequencer for the convolution datapath: on a `start` pulse it walks every output position of a single-channel IMG_H x IMG_W feature map and, for each, every tap of a K x K kernel. It emits one pixel address plus weight index per accepted beat. Accumulator framing strobes mark the first and last tap of each window. It replaces the free-running cascaded index counter with a start/done, backpressure-aware controller that sits between the layer-level FSM and the MAC/line-buffer datapath.

## Interface
- IMG_W, 28, input feature map width in pixels (>= K)
- IMG_H, 28, input feature map height in pixels (>= K)
- K, 3, kernel edge length (>= 1)
- ADDR_W, 10, pixel address width; must hold IMG_W*IMG_H-1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a scan; honoured only in IDLE
- abort  in  1  cancel scan; return to IDLE, no done
- tap_ready  in  1  datapath accepts current beat
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final tap is accepted
- tap_valid  out  1  beat on pix_addr/w_idx is valid
- pix_addr  out  ADDR_W  (out_row+kr)*IMG_W + (out_col+kc)
- w_idx  out  clog2(K*K)  kr*K + kc
- acc_first  out  1  beat is tap (0,0) of a window; accumulator clears
- acc_last  out  1  beat is tap (K-1,K-1); accumulator result valid
- out_row  out  7  current output row
- out_col  out  7  current output column

## Operation
- Derived values: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1. Stride is 1 and there is no padding.
- States:
  - IDLE -> RUN on start (and not abort).
  - RUN -> DONE after a beat with tap_valid && tap_ready on the last tap of the last window.
  - RUN -> IDLE on abort.
  - DONE -> IDLE unconditionally.
- Loop order, innermost first: kc, kr, out_col, out_row. Each counter wraps to 0 and carries into the next.
- Advance happens only on a handshake (tap_valid && tap_ready). When tap_ready=0, every output holds stable.
- tap_valid = 1 for the whole of RUN and 0 in IDLE and DONE.
- start while busy or in DONE: ignored.
- abort has priority over start and over handshake completion in the same cycle. It is ignored in IDLE and DONE.
- pix_addr is computed incrementally from a registered row base (add IMG_W per row step) with no multiplier. It must equal the formula exactly. It never exceeds IMG_W*IMG_H-1.
- Reset values: state IDLE; busy, done, tap_valid, acc_first, acc_last = 0; pix_addr, w_idx, out_row, out_col = 0; all counters = 0.

## Timing
- All outputs are registered.
- start sampled high in IDLE at edge n: busy=1, tap_valid=1, pix_addr=0, w_idx=0, acc_first=1 from edge n.
- With tap_ready held at 1, one tap per cycle; total beats = OUT_H*OUT_W*K*K.
- done is high exactly one cycle, the cycle after the final handshake, with busy=0 and tap_valid=0. The earliest next start is then accepted in the following IDLE cycle.
- abort sampled at edge n: IDLE from n+1, tap_valid=0, counters cleared, no done.
- rst mid-scan: the reset values above apply after the next edge, and no done is generated.
- When K=1: acc_first and acc_last are both high on every beat.

## Structure
- Shared package `cnn_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam functions for OUT_W, OUT_H and the w_idx width;
  - the default IMG_W, IMG_H and K constants shared with the datapath.
- One sub-module, `conv_idx_counter`: a parameterised modulo-N counter with inputs clk, rst, clr, en, and outputs value and wrap (wrap = en && value==N-1). It is instantiated four times (kc, kr, out_col, out_row), with each instance's wrap chained into the next instance's en.
- The FSM, address base register and strobes live in the top module.

## Test plan
- IMG 5x5, K=3, tap_ready=1, start pulse:
  - 81 beats; done pulses one cycle after beat 81;
  - first window pix_addr sequence = 0,1,2,5,6,7,10,11,12 with w_idx 0..8;
  - last beat pix_addr=24, out_row=2, out_col=2, acc_last=1.
- Same config with tap_ready toggling 1,0,1,0: outputs hold while tap_ready=0; 81 handshakes complete; done occurs after 161 cycles of RUN.
- Same config, abort asserted on beat 20: IDLE next cycle, tap_valid=0, no done. A new start then restarts from pix_addr=0.
- Same config, start reasserted mid-scan and during DONE: no effect, and the beat count remains 81. start and abort asserted together in IDLE: stays in IDLE.
- Same config, rst asserted on beat 40: next cycle all outputs are 0. A following start produces a full 81-beat scan.
- IMG 4x4, K=1: 16 beats, pix_addr 0..15, acc_first=acc_last=1 on every beat. IMG 3x3, K=3: exactly 9 beats, then done.
